// File: rtl/rvh_pkg.sv
// rtl/rvh_pkg.sv - shared core widths and L1 instruction-cache fetch/refill types
package rvh_pkg;

  localparam int FETCH_WIDTH = 128;
  localparam int VADDR_WIDTH = 39;
  localparam int PADDR_WIDTH = 40;

  localparam int L1IC_SET_COUNT    = 16;
  localparam int L1IC_LINE_SIZE    = 64;
  localparam int L1IC_OFFSET_WIDTH = $clog2(L1IC_LINE_SIZE);
  localparam int L1IC_INDEX_WIDTH  = $clog2(L1IC_SET_COUNT);
  localparam int L1IC_TAG_WIDTH    = VADDR_WIDTH - L1IC_INDEX_WIDTH - L1IC_OFFSET_WIDTH;

  typedef struct packed {
    logic [VADDR_WIDTH-1:0] pc;
  } l1ic_req_t;

  typedef struct packed {
    logic                   replay;
    logic [FETCH_WIDTH-1:0] line;
  } l1ic_resp_t;

  typedef struct packed {
    logic [PADDR_WIDTH-1:0] addr;
  } l1ic_mem_req_t;

endpackage

// File: rtl/l1ic_refill_ctrl.sv
// rtl/l1ic_refill_ctrl.sv - single-outstanding line refill sequencer for the L1 icache
// Owns the IDLE/REQ/FILL FSM, beat counter, line buffer and the pending-flush flag.
module l1ic_refill_ctrl
  import rvh_pkg::*;
#(
  parameter int SET_COUNT      = L1IC_SET_COUNT,
  parameter int LINE_SIZE      = L1IC_LINE_SIZE,
  parameter int MEM_DATA_WIDTH = 64,
  localparam int OFFSET_W  = $clog2(LINE_SIZE),
  localparam int INDEX_W   = $clog2(SET_COUNT),
  localparam int TAG_W     = VADDR_WIDTH - INDEX_W - OFFSET_W,
  localparam int LINE_BITS = LINE_SIZE * 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start_i,
  input  logic [PADDR_WIDTH-1:0]    start_addr_i,
  input  logic                      flush_i,
  output logic                      busy_o,
  output logic                      mem_req_vld_o,
  output logic [PADDR_WIDTH-1:0]    mem_req_addr_o,
  input  logic                      mem_req_rdy_i,
  input  logic                      mem_resp_vld_i,
  input  logic [MEM_DATA_WIDTH-1:0] mem_resp_data_i,
  output logic                      install_vld_o,
  output logic [INDEX_W-1:0]        install_idx_o,
  output logic [TAG_W-1:0]          install_tag_o,
  output logic [LINE_BITS-1:0]      install_line_o
);

  localparam int BEATS = LINE_BITS / MEM_DATA_WIDTH;
  localparam int CNT_W = $clog2(BEATS);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_FILL = 2'd2;

  logic [1:0]           state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [LINE_BITS-1:0] buf_q, buf_d;
  logic                 flush_pend_q, flush_pend_d;
  l1ic_mem_req_t        mem_req_q, mem_req_d;
  logic                 last_beat;

  assign last_beat = (state_q == S_FILL) && mem_resp_vld_i && (cnt_q == CNT_W'(BEATS - 1));

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    buf_d        = buf_q;
    flush_pend_d = flush_pend_q;
    mem_req_d    = mem_req_q;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          state_d        = S_REQ;
          mem_req_d.addr = start_addr_i;
        end
      end
      S_REQ: begin
        if (mem_req_rdy_i) begin
          state_d = S_FILL;
          cnt_d   = '0;
        end
      end
      S_FILL: begin
        if (mem_resp_vld_i) begin
          buf_d[int'(cnt_q) * MEM_DATA_WIDTH +: MEM_DATA_WIDTH] = mem_resp_data_i;
          cnt_d = cnt_q + CNT_W'(1);
          if (last_beat) begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (flush_i && (state_q != S_IDLE)) begin
      flush_pend_d = 1'b1;
    end
    if (last_beat) begin
      flush_pend_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      flush_pend_q <= 1'b0;
      mem_req_q    <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      flush_pend_q <= flush_pend_d;
      mem_req_q    <= mem_req_d;
    end
  end

  always_ff @(posedge clk) begin
    buf_q <= buf_d;
  end

  assign busy_o         = (state_q != S_IDLE);
  assign mem_req_vld_o  = (state_q == S_REQ);
  assign mem_req_addr_o = mem_req_q.addr;

  // A flush landing on the last beat itself must also keep the stale line out.
  assign install_vld_o  = last_beat && !flush_pend_q && !flush_i;
  assign install_idx_o  = mem_req_q.addr[OFFSET_W +: INDEX_W];
  assign install_tag_o  = mem_req_q.addr[OFFSET_W + INDEX_W +: TAG_W];
  assign install_line_o = buf_d;

endmodule

// File: rtl/l1ic_fetch_responder.sv
// rtl/l1ic_fetch_responder.sv - direct-mapped flop-based L1 icache answering IFU fetches
// Holds valid/tag/data arrays, the hit lookup and the registered fetch response.
module l1ic_fetch_responder
  import rvh_pkg::*;
#(
  parameter int SET_COUNT      = L1IC_SET_COUNT,
  parameter int LINE_SIZE      = L1IC_LINE_SIZE,
  parameter int MEM_DATA_WIDTH = 64
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      req_vld_i,
  input  l1ic_req_t                 req_i,
  output logic                      req_rdy_o,
  output logic                      resp_vld_o,
  output l1ic_resp_t                resp_o,
  input  logic                      flush_i,
  output logic                      mem_req_vld_o,
  output logic [PADDR_WIDTH-1:0]    mem_req_addr_o,
  input  logic                      mem_req_rdy_i,
  input  logic                      mem_resp_vld_i,
  input  logic [MEM_DATA_WIDTH-1:0] mem_resp_data_i
);

  localparam int OFFSET_W  = $clog2(LINE_SIZE);
  localparam int INDEX_W   = $clog2(SET_COUNT);
  localparam int TAG_W     = VADDR_WIDTH - INDEX_W - OFFSET_W;
  localparam int LINE_BITS = LINE_SIZE * 8;
  localparam int BLK_W     = $clog2(LINE_BITS / FETCH_WIDTH);

  logic [SET_COUNT-1:0] valid_q;
  logic [TAG_W-1:0]     tag_q  [SET_COUNT];
  logic [LINE_BITS-1:0] data_q [SET_COUNT];

  logic                 resp_vld_q;
  l1ic_resp_t           resp_q, resp_d;

  logic [INDEX_W-1:0]   req_idx;
  logic [TAG_W-1:0]     req_tag;
  logic [BLK_W-1:0]     req_blk;
  logic [PADDR_WIDTH-1:0] req_line_addr;
  logic                 hit;
  logic                 busy;
  logic                 start;

  logic                 install_vld;
  logic [INDEX_W-1:0]   install_idx;
  logic [TAG_W-1:0]     install_tag;
  logic [LINE_BITS-1:0] install_line;

  logic                 unused_pc_bits;

  assign req_idx = req_i.pc[OFFSET_W +: INDEX_W];
  assign req_tag = req_i.pc[OFFSET_W + INDEX_W +: TAG_W];
  assign req_blk = req_i.pc[OFFSET_W - 1 -: BLK_W];
  assign req_line_addr = {{(PADDR_WIDTH - VADDR_WIDTH){1'b0}},
                          req_i.pc[VADDR_WIDTH-1:OFFSET_W], {OFFSET_W{1'b0}}};
  assign unused_pc_bits = ^req_i.pc[OFFSET_W - BLK_W - 1:0];

  assign hit       = valid_q[req_idx] && (tag_q[req_idx] == req_tag);
  assign req_rdy_o = 1'b1;

  // Only a clean IDLE-state miss may launch a refill; busy or flushing cycles just replay.
  assign start = req_vld_i && !busy && !hit && !flush_i;

  l1ic_refill_ctrl #(
    .SET_COUNT      (SET_COUNT),
    .LINE_SIZE      (LINE_SIZE),
    .MEM_DATA_WIDTH (MEM_DATA_WIDTH)
  ) u_refill (
    .clk             (clk),
    .rst_n           (rst_n),
    .start_i         (start),
    .start_addr_i    (req_line_addr),
    .flush_i         (flush_i),
    .busy_o          (busy),
    .mem_req_vld_o   (mem_req_vld_o),
    .mem_req_addr_o  (mem_req_addr_o),
    .mem_req_rdy_i   (mem_req_rdy_i),
    .mem_resp_vld_i  (mem_resp_vld_i),
    .mem_resp_data_i (mem_resp_data_i),
    .install_vld_o   (install_vld),
    .install_idx_o   (install_idx),
    .install_tag_o   (install_tag),
    .install_line_o  (install_line)
  );

  always_comb begin
    resp_d = '0;
    if (req_vld_i) begin
      resp_d.replay = !(hit && !busy && !flush_i);
      if (!resp_d.replay) begin
        resp_d.line = data_q[req_idx][int'(req_blk) * FETCH_WIDTH +: FETCH_WIDTH];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q    <= '0;
      resp_vld_q <= 1'b0;
      resp_q     <= '0;
    end else begin
      resp_vld_q <= req_vld_i;
      resp_q     <= resp_d;
      if (flush_i) begin
        valid_q <= '0;
      end else if (install_vld) begin
        valid_q[install_idx] <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (install_vld) begin
      tag_q[install_idx]  <= install_tag;
      data_q[install_idx] <= install_line;
    end
  end

  assign resp_vld_o = resp_vld_q;
  assign resp_o     = resp_q;

endmodule

// File: tb/tb_l1ic_fetch_responder.sv
// tb/tb_l1ic_fetch_responder.sv - scoreboard bench for the L1 icache fetch responder
module tb_l1ic_fetch_responder;
  import rvh_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        req_vld_i;
  l1ic_req_t   req_i;
  logic        req_rdy_o;
  logic        resp_vld_o;
  l1ic_resp_t  resp_o;
  logic        flush_i;
  logic        mem_req_vld_o;
  logic [39:0] mem_req_addr_o;
  logic        mem_req_rdy_i;
  logic        mem_resp_vld_i;
  logic [63:0] mem_resp_data_i;

  typedef struct {
    int           due;
    logic         replay;
    logic [127:0] line;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  l1ic_fetch_responder dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .req_vld_i       (req_vld_i),
    .req_i           (req_i),
    .req_rdy_o       (req_rdy_o),
    .resp_vld_o      (resp_vld_o),
    .resp_o          (resp_o),
    .flush_i         (flush_i),
    .mem_req_vld_o   (mem_req_vld_o),
    .mem_req_addr_o  (mem_req_addr_o),
    .mem_req_rdy_i   (mem_req_rdy_i),
    .mem_resp_vld_i  (mem_resp_vld_i),
    .mem_resp_data_i (mem_resp_data_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [159:0] got, input logic [159:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [63:0] beat(input logic [7:0] seed, input int k);
    logic [63:0] r;
    for (int b = 0; b < 8; b++) r[b*8 +: 8] = seed + 8'(8 * k + b);
    return r;
  endfunction

  function automatic logic [127:0] blk(input logic [7:0] seed, input logic [38:0] pc);
    logic [511:0] l;
    int           sel;
    for (int k = 0; k < 8; k++) l[k*64 +: 64] = beat(seed, k);
    sel = int'(pc[5:4]);
    return l[sel*128 +: 128];
  endfunction

  // Response monitor: each request's answer is due exactly one cycle after it is driven.
  always @(negedge clk) begin
    if (sb.size() != 0 && sb[0].due == cyc) begin
      check_eq("resp_vld", resp_vld_o, 1'b1);
      check_eq("resp_replay", resp_o.replay, sb[0].replay);
      check_eq("resp_line", resp_o.line, sb[0].line);
      void'(sb.pop_front());
    end else if (resp_vld_o) begin
      check_eq("stray_resp", resp_vld_o, 1'b0);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    req_vld_i      = 1'b0;
    flush_i        = 1'b0;
    mem_req_rdy_i  = 1'b0;
    mem_resp_vld_i = 1'b0;
  endtask

  task automatic req(input logic [38:0] pc, input logic rep, input logic [127:0] line);
    exp_t e;
    req_vld_i = 1'b1;
    req_i.pc  = pc;
    e.due = cyc + 1;
    e.replay = rep;
    e.line = line;
    sb.push_back(e);
  endtask

  task automatic refill(input logic [39:0] ea, input logic [7:0] seed, input int delay,
                        input int flush_at, input int side_at, input logic [38:0] side_pc);
    int w = 0;
    while (mem_req_vld_o !== 1'b1 && w < 20) begin
      tick();
      w++;
    end
    check_eq("mem_req_vld", mem_req_vld_o, 1'b1);
    check_eq("mem_req_addr", mem_req_addr_o, ea);
    for (int i = 0; i < delay; i++) begin
      tick();
      check_eq("bp_vld", mem_req_vld_o, 1'b1);
      check_eq("bp_addr", mem_req_addr_o, ea);
    end
    mem_req_rdy_i = 1'b1;
    tick();
    check_eq("mem_req_done", mem_req_vld_o, 1'b0);
    for (int k = 0; k < 8; k++) begin
      mem_resp_vld_i  = 1'b1;
      mem_resp_data_i = beat(seed, k);
      if (k == flush_at) flush_i = 1'b1;
      if (k == side_at) req(side_pc, 1'b1, '0);
      tick();
      check_eq("fill_no_mem_req", mem_req_vld_o, 1'b0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout at cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; req_vld_i = 1'b0; req_i = '0; flush_i = 1'b0;
    mem_req_rdy_i = 1'b0; mem_resp_vld_i = 1'b0; mem_resp_data_i = '0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_resp_vld", resp_vld_o, 1'b0);
    check_eq("rst_resp", resp_o, '0);
    check_eq("rst_mem_vld", mem_req_vld_o, 1'b0);
    check_eq("rst_mem_addr", mem_req_addr_o, '0);
    check_eq("req_rdy", req_rdy_o, 1'b1);
    rst_n = 1'b1;
    tick();

    // cold miss, replay on the install cycle, then hits in every block of the line
    req(39'h80000010, 1'b1, '0);
    tick();
    refill(40'h0080000000, 8'h00, 0, -1, 7, 39'h80000010);
    req(39'h80000010, 1'b0, blk(8'h00, 39'h80000010)); tick();
    check_eq("spec_block1", blk(8'h00, 39'h80000010),
             128'h1f1e1d1c1b1a1918_1716151413121110);
    req(39'h80000000, 1'b0, blk(8'h00, 39'h80000000)); tick();
    req(39'h8000003C, 1'b0, blk(8'h00, 39'h8000003C)); tick();

    // conflict eviction with backpressure and a request to another line during FILL
    req(39'h80000400, 1'b1, '0); tick();
    refill(40'h0080000400, 8'h40, 5, -1, 3, 39'h80000800);
    req(39'h80000420, 1'b0, blk(8'h40, 39'h80000420)); tick();
    req(39'h80000000, 1'b1, '0); tick();
    refill(40'h0080000000, 8'h80, 0, -1, -1, '0);
    req(39'h80000000, 1'b0, blk(8'h80, 39'h80000000)); tick();

    // hit while refill is in REQ replays; flush mid-FILL suppresses the install
    req(39'h80001040, 1'b1, '0); tick();
    req(39'h80000000, 1'b1, '0); tick();
    refill(40'h0080001040, 8'hC0, 0, 3, -1, '0);
    req(39'h80001040, 1'b1, '0); tick();
    refill(40'h0080001040, 8'hC0, 0, -1, -1, '0);
    req(39'h80001070, 1'b0, blk(8'hC0, 39'h80001070)); tick();

    // flush in IDLE with a concurrent request: replay, no refill, all lines gone
    req(39'h80001040, 1'b1, '0);
    flush_i = 1'b1;
    tick();
    check_eq("flush_no_mem_req", mem_req_vld_o, 1'b0);
    tick();
    check_eq("flush_no_mem_req2", mem_req_vld_o, 1'b0);
    req(39'h80001040, 1'b1, '0); tick();
    refill(40'h0080001040, 8'h11, 0, -1, -1, '0);
    req(39'h80001050, 1'b0, blk(8'h11, 39'h80001050)); tick();

    // reset after three beats of a refill
    req(39'h80003000, 1'b1, '0); tick();
    mem_req_rdy_i = 1'b1; tick();
    for (int k = 0; k < 3; k++) begin
      mem_resp_vld_i = 1'b1; mem_resp_data_i = beat(8'h55, k); tick();
    end
    rst_n = 1'b0;
    #2;
    check_eq("mid_rst_resp_vld", resp_vld_o, 1'b0);
    check_eq("mid_rst_resp", resp_o, '0);
    check_eq("mid_rst_mem_vld", mem_req_vld_o, 1'b0);
    check_eq("mid_rst_mem_addr", mem_req_addr_o, '0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int k = 3; k < 5; k++) begin
      mem_resp_vld_i = 1'b1; mem_resp_data_i = beat(8'h55, k); tick();
      check_eq("post_rst_idle", mem_req_vld_o, 1'b0);
    end
    req(39'h80001040, 1'b1, '0); tick();
    refill(40'h0080001040, 8'h22, 0, -1, -1, '0);
    req(39'h80001040, 1'b0, blk(8'h22, 39'h80001040)); tick();

    tick(); tick();
    check_eq("sb_drained", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
